alu_accumulator: RTL and testbench

ALU_ACCUMULATOR -- requirements
Module: alu_accumulator

---
 rtl/alu_accumulator_if.sv | 37 +++
 rtl/alu_accumulator.sv | 115 +++++++++++
 tb/tb_alu_accumulator.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/alu_accumulator_if.sv
// Bundle of the instruction handshake, external-ALU hookup and status outputs
// of the ALU accumulator.
interface alu_accumulator_if;
  logic       instrValid;
  logic       instrReady;
  logic [1:0] cmd;
  logic       opMode;
  logic [3:0] opFunc;
  logic       opCarry;
  logic       useFlag;
  logic [3:0] operand;
  logic       aluCarryIn;
  logic       aluMode;
  logic [3:0] aluFunc;
  logic [3:0] aluA;
  logic [3:0] aluB;
  logic [3:0] aluData;
  logic       aluCarryOut;
  logic [3:0] accOut;
  logic       carryFlag;
  logic       zeroFlag;
  logic       done;

  // Accumulator side
  modport slave (
    input  instrValid, cmd, opMode, opFunc, opCarry, useFlag, operand, aluData, aluCarryOut,
    output instrReady, aluCarryIn, aluMode, aluFunc, aluA, aluB, accOut, carryFlag, zeroFlag,
           done
  );

  // Instruction source and external ALU side
  modport master (
    output instrValid, cmd, opMode, opFunc, opCarry, useFlag, operand, aluData, aluCarryOut,
    input  instrReady, aluCarryIn, aluMode, aluFunc, aluA, aluB, accOut, carryFlag, zeroFlag,
           done
  );
endinterface

// File: rtl/alu_accumulator.sv
// 4-bit accumulator sequencing an external combinational ALU.
// Each instruction goes IDLE -> EXEC -> DONE, so latency is fixed for all commands.
module alu_accumulator (
  input  logic         clock,
  input  logic         reset,
  alu_accumulator_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  localparam logic [1:0] CmdAlu   = 2'b00;
  localparam logic [1:0] CmdLoad  = 2'b01;
  localparam logic [1:0] CmdCmp   = 2'b10;
  localparam logic [1:0] CmdClrC  = 2'b11;

  state_e     state_q, state_d;
  logic [1:0] cmd_q, cmd_d;
  logic       mode_q, mode_d;
  logic [3:0] func_q, func_d;
  logic       cin_q, cin_d;
  logic [3:0] operand_q, operand_d;
  logic [3:0] acc_q, acc_d;
  logic       carry_q, carry_d;
  logic       zero_q, zero_d;

  // State and datapath registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      cmd_q     <= 2'b00;
      mode_q    <= 1'b0;
      func_q    <= 4'b0000;
      cin_q     <= 1'b0;
      operand_q <= 4'b0000;
      acc_q     <= 4'b0000;
      carry_q   <= 1'b0;
      zero_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      mode_q    <= mode_d;
      func_q    <= func_d;
      cin_q     <= cin_d;
      operand_q <= operand_d;
      acc_q     <= acc_d;
      carry_q   <= carry_d;
      zero_q    <= zero_d;
    end
  end

  // Next-state: accept only in IDLE, always pass through EXEC and DONE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.instrValid) state_d = StExec;
      StExec:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Instruction latch on acceptance and commit at the end of EXEC
  always_comb begin
    cmd_d     = cmd_q;
    mode_d    = mode_q;
    func_d    = func_q;
    cin_d     = cin_q;
    operand_d = operand_q;
    acc_d     = acc_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    if (state_q == StIdle && bus.instrValid) begin
      cmd_d     = bus.cmd;
      mode_d    = bus.opMode;
      func_d    = bus.opFunc;
      operand_d = bus.operand;
      // carry_q cannot change before EXEC ends, so resolving here keeps aluCarryIn stable
      cin_d     = bus.useFlag ? carry_q : bus.opCarry;
    end
    if (state_q == StExec) begin
      unique case (cmd_q)
        CmdAlu: begin
          acc_d   = bus.aluData;
          carry_d = bus.aluCarryOut;
          zero_d  = (bus.aluData == 4'b0000);
        end
        CmdLoad: begin
          acc_d  = operand_q;
          zero_d = (operand_q == 4'b0000);
        end
        CmdCmp: begin
          carry_d = bus.aluCarryOut;
          zero_d  = (bus.aluData == 4'b0000);
        end
        CmdClrC: carry_d = 1'b0;
        default: ;
      endcase
    end
  end

  // Outputs: handshake decoded from state, ALU driven from the latched fields
  always_comb begin
    bus.instrReady = (state_q == StIdle);
    bus.done       = (state_q == StDone);
    bus.aluA       = acc_q;
    bus.aluB       = operand_q;
    bus.aluMode    = mode_q;
    bus.aluFunc    = func_q;
    bus.aluCarryIn = cin_q;
    bus.accOut     = acc_q;
    bus.carryFlag  = carry_q;
    bus.zeroFlag   = zero_q;
  end

endmodule

// File: tb/tb_alu_accumulator.sv
// Directed bench for alu_accumulator with a small 74181-style ALU model
// (active-low carry-in/out) attached to the ALU port.
module tb_alu_accumulator;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  alu_accumulator_if bus_if ();

  alu_accumulator u_dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU: mode 0 func 1001 = A plus B, func 0110 = A minus B minus 1 plus carry,
  // carry lines active-low; anything else is A xor B with no carry.
  logic [4:0] alu_sum;
  logic [3:0] alu_b_eff;
  always_comb begin
    alu_sum   = 5'b00000;
    alu_b_eff = (bus_if.aluFunc == 4'b0110) ? ~bus_if.aluB : bus_if.aluB;
    if (!bus_if.aluMode && (bus_if.aluFunc == 4'b1001 || bus_if.aluFunc == 4'b0110)) begin
      alu_sum            = {1'b0, bus_if.aluA} + {1'b0, alu_b_eff} + {4'b0000, ~bus_if.aluCarryIn};
      bus_if.aluData     = alu_sum[3:0];
      bus_if.aluCarryOut = ~alu_sum[4];
    end else begin
      bus_if.aluData     = bus_if.aluA ^ bus_if.aluB;
      bus_if.aluCarryOut = 1'b1;
    end
  end

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_state(input string tag, input logic [3:0] acc, input logic c,
                             input logic z);
    check_eq({tag, "_acc"}, {4'h0, bus_if.accOut}, {4'h0, acc});
    check_eq({tag, "_carry"}, {7'h0, bus_if.carryFlag}, {7'h0, c});
    check_eq({tag, "_zero"}, {7'h0, bus_if.zeroFlag}, {7'h0, z});
  endtask

  // Issue one instruction from an IDLE negedge; returns at the IDLE negedge after DONE.
  task automatic run(input string tag, input logic [1:0] c, input logic m, input logic [3:0] f,
                     input logic oc, input logic uf, input logic [3:0] op,
                     input logic [3:0] exp_a, input logic exp_cin);
    check_eq({tag, "_ready_idle"}, {7'h0, bus_if.instrReady}, 8'h01);
    bus_if.cmd        = c;
    bus_if.opMode     = m;
    bus_if.opFunc     = f;
    bus_if.opCarry    = oc;
    bus_if.useFlag    = uf;
    bus_if.operand    = op;
    bus_if.instrValid = 1'b1;
    @(negedge clk);
    bus_if.instrValid = 1'b0;
    check_eq({tag, "_ready_exec"}, {7'h0, bus_if.instrReady}, 8'h00);
    check_eq({tag, "_done_exec"}, {7'h0, bus_if.done}, 8'h00);
    check_eq({tag, "_alu_a"}, {4'h0, bus_if.aluA}, {4'h0, exp_a});
    check_eq({tag, "_alu_b"}, {4'h0, bus_if.aluB}, {4'h0, op});
    check_eq({tag, "_alu_func"}, {3'h0, bus_if.aluMode, bus_if.aluFunc}, {3'h0, m, f});
    check_eq({tag, "_alu_cin"}, {7'h0, bus_if.aluCarryIn}, {7'h0, exp_cin});
    @(negedge clk);
    check_eq({tag, "_done"}, {7'h0, bus_if.done}, 8'h01);
    check_eq({tag, "_ready_done"}, {7'h0, bus_if.instrReady}, 8'h00);
    check_eq({tag, "_alu_b_hold"}, {4'h0, bus_if.aluB}, {4'h0, op});
    @(negedge clk);
    check_eq({tag, "_done_clr"}, {7'h0, bus_if.done}, 8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] tp_ops [3];
    tp_ops[0] = 4'b0001;
    tp_ops[1] = 4'b0010;
    tp_ops[2] = 4'b0011;
    n_checks = 0;
    n_pass   = 0;
    rst               = 1'b1;
    bus_if.instrValid = 1'b0;
    bus_if.cmd        = 2'b00;
    bus_if.opMode     = 1'b0;
    bus_if.opFunc     = 4'b0000;
    bus_if.opCarry    = 1'b0;
    bus_if.useFlag    = 1'b0;
    bus_if.operand    = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_state("reset", 4'b0000, 1'b0, 1'b1);
    check_eq("reset_ready", {7'h0, bus_if.instrReady}, 8'h01);
    check_eq("reset_done", {7'h0, bus_if.done}, 8'h00);
    check_eq("reset_alu", {bus_if.aluA, bus_if.aluB}, 8'h00);
    check_eq("reset_alu_ctl", {2'b00, bus_if.aluCarryIn, bus_if.aluMode, bus_if.aluFunc}, 8'h00);

    // Load then A+B with active-low carry-in deasserted: 1100 + 0011 = 1111, no carry (cout=1)
    run("load1", 2'b01, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b1100, 4'b0000, 1'b0);
    check_state("load1", 4'b1100, 1'b0, 1'b0);
    run("add1", 2'b00, 1'b0, 4'b1001, 1'b1, 1'b0, 4'b0011, 4'b1100, 1'b1);
    check_state("add1", 4'b1111, 1'b1, 1'b0);

    // Load keeps carry; compare 1100-0011 -> 1001 with carry out 0, acc untouched
    run("load2", 2'b01, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b1100, 4'b1111, 1'b0);
    check_state("load2", 4'b1100, 1'b1, 1'b0);
    run("cmp", 2'b10, 1'b0, 4'b0110, 1'b0, 1'b0, 4'b0011, 4'b1100, 1'b0);
    check_state("cmp", 4'b1100, 1'b0, 1'b0);

    // Carry-in from flag: flag=1 overrides opCarry=0; 1111+0000 -> 1111, cout=1
    run("add2", 2'b00, 1'b0, 4'b1001, 1'b1, 1'b0, 4'b0011, 4'b1100, 1'b1);
    check_state("add2", 4'b1111, 1'b1, 1'b0);
    run("addflag1", 2'b00, 1'b0, 4'b1001, 1'b0, 1'b1, 4'b0000, 4'b1111, 1'b1);
    check_state("addflag1", 4'b1111, 1'b1, 1'b0);
    run("clrc", 2'b11, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b1111, 1'b1);
    check_state("clrc", 4'b1111, 1'b0, 1'b0);
    run("load0", 2'b01, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b1111, 1'b0);
    check_state("load0", 4'b0000, 1'b0, 1'b1);

    // Flag=0 overrides opCarry=1: 0000+0000+1 -> 0001, cout=1
    run("addflag0", 2'b00, 1'b0, 4'b1001, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0);
    check_state("addflag0", 4'b0001, 1'b1, 1'b0);

    // instrValid held high: one acceptance every third cycle, in order
    bus_if.cmd     = 2'b01;
    bus_if.useFlag = 1'b0;
    bus_if.opCarry = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("tp%0d_ready_idle", k), {7'h0, bus_if.instrReady}, 8'h01);
      bus_if.operand    = tp_ops[k];
      bus_if.instrValid = 1'b1;
      @(negedge clk);
      check_eq($sformatf("tp%0d_ready_exec", k), {7'h0, bus_if.instrReady}, 8'h00);
      check_eq($sformatf("tp%0d_alu_b", k), {4'h0, bus_if.aluB}, {4'h0, tp_ops[k]});
      @(negedge clk);
      check_eq($sformatf("tp%0d_ready_done", k), {7'h0, bus_if.instrReady}, 8'h00);
      check_eq($sformatf("tp%0d_done", k), {7'h0, bus_if.done}, 8'h01);
      check_eq($sformatf("tp%0d_acc", k), {4'h0, bus_if.accOut}, {4'h0, tp_ops[k]});
      @(negedge clk);
    end
    bus_if.instrValid = 1'b0;
    check_eq("tp_idle_done", {7'h0, bus_if.done}, 8'h00);

    // Reset in EXEC of a load 0101 abandons it
    bus_if.cmd        = 2'b01;
    bus_if.operand    = 4'b0101;
    bus_if.instrValid = 1'b1;
    @(negedge clk);
    bus_if.instrValid = 1'b0;
    check_eq("rstexec_ready", {7'h0, bus_if.instrReady}, 8'h00);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rstexec_done", {7'h0, bus_if.done}, 8'h00);
    check_eq("rstexec_ready_idle", {7'h0, bus_if.instrReady}, 8'h01);
    check_state("rstexec", 4'b0000, 1'b0, 1'b1);
    check_eq("rstexec_alu_b", {4'h0, bus_if.aluB}, 8'h00);
    @(negedge clk);
    check_eq("rstexec_done_after", {7'h0, bus_if.done}, 8'h00);
    check_eq("rstexec_acc_after", {4'h0, bus_if.accOut}, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
